// File: rtl/lcd_saida_dados_if.sv
// Strobe/value input and LCD pin group for lcd_saida_dados.
// The master modport is the control-unit/bench side, slave is the LCD driver.
interface lcd_saida_dados_if;
    logic        out;
    logic [31:0] dados;
    logic        busy;
    logic [7:0]  LCD_DATA;
    logic        LCD_RS;
    logic        LCD_RW;
    logic        LCD_EN;

    modport master (
        output out, dados,
        input  busy, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
    );

    modport slave (
        input  out, dados,
        output busy, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
    );
endinterface

// File: rtl/lcd_saida_dados.sv
// HD44780-style LCD writer: power-up wait, init commands, then an 8-digit hex dump of the latest strobed word.
// busy is low only when idle with nothing pending; LCD_ECHO_LINE2_EN echoes the previous word on line 2.
module lcd_saida_dados #(
    parameter int POWERUP_CYCLES = 750000,
    parameter int EN_CYCLES      = 12,
    parameter int WAIT_CYCLES    = 2000,
    parameter int CLEAR_CYCLES   = 82000
) (
    input logic              clock,
    input logic              reset,
    lcd_saida_dados_if.slave bus
);
    typedef enum logic [2:0] {
        PWRUP, INIT, IDLE, WR_ADDR, WR_CHAR
`ifdef LCD_ECHO_LINE2_EN
        , WR_ADDR2, WR_CHAR2
`endif
    } state_t;

    typedef enum logic [1:0] {B_IDLE, B_SETUP, B_PULSE, B_WAIT} phase_t;

    state_t      state;
    phase_t      phase;
    logic [31:0] cnt;
    logic [2:0]  idx;
    logic        pend;
    logic [31:0] pend_val;
    logic [31:0] disp;
`ifdef LCD_ECHO_LINE2_EN
    logic [31:0] prev;
`endif
    logic [7:0]  data_q;
    logic        rs_q;
    logic        en_q;
    logic        clr_q;
    logic        byte_done;

    assign byte_done = (phase == B_WAIT) &&
                       (cnt == (clr_q ? 32'(CLEAR_CYCLES - 1) : 32'(WAIT_CYCLES - 1)));

    assign bus.LCD_DATA = data_q;
    assign bus.LCD_RS   = rs_q;
    assign bus.LCD_RW   = 1'b0;
    assign bus.LCD_EN   = en_q;
    assign bus.busy     = !((state == IDLE) && !pend);

    function automatic logic [7:0] hex_char(input logic [31:0] w, input logic [2:0] i);
        logic [2:0] k;
        logic [3:0] n;
        k = 3'd7 - i;
        n = w[{k, 2'b00} +: 4];
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Loads RS/DATA for the whole byte and kicks the SETUP->PULSE->WAIT engine.
    task automatic start_byte(input logic [7:0] d, input logic rs);
        data_q <= d;
        rs_q   <= rs;
        clr_q  <= !rs && (d == 8'h01);
        phase  <= B_SETUP;
        cnt    <= '0;
    endtask

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= PWRUP;
            phase    <= B_IDLE;
            cnt      <= '0;
            idx      <= '0;
            pend     <= 1'b0;
            pend_val <= '0;
            disp     <= '0;
`ifdef LCD_ECHO_LINE2_EN
            prev     <= '0;
`endif
            data_q   <= 8'h00;
            rs_q     <= 1'b0;
            en_q     <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            case (phase)
                B_SETUP: begin
                    phase <= B_PULSE;
                    en_q  <= 1'b1;
                    cnt   <= '0;
                end
                B_PULSE: begin
                    if (cnt == 32'(EN_CYCLES - 1)) begin
                        en_q  <= 1'b0;
                        phase <= B_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                B_WAIT: begin
                    if (byte_done) phase <= B_IDLE;
                    else           cnt   <= cnt + 32'd1;
                end
                default: ;
            endcase

            // Next byte is issued on the same edge the previous WAIT ends.
            case (state)
                PWRUP: begin
                    if (cnt == 32'(POWERUP_CYCLES - 1)) begin
                        state <= INIT;
                        idx   <= '0;
                        start_byte(init_cmd(3'd0), 1'b0);
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                INIT: begin
                    if (byte_done) begin
                        if (idx == 3'd3) begin
                            state <= IDLE;
                        end else begin
                            idx <= idx + 3'd1;
                            start_byte(init_cmd(idx + 3'd1), 1'b0);
                        end
                    end
                end
                IDLE: begin
                    if (pend) begin
                        disp <= pend_val;
                        pend <= 1'b0;
`ifdef LCD_ECHO_LINE2_EN
                        prev  <= disp;
                        state <= WR_ADDR2;
                        start_byte(8'hC0, 1'b0);
`else
                        state <= WR_ADDR;
                        start_byte(8'h80, 1'b0);
`endif
                    end
                end
`ifdef LCD_ECHO_LINE2_EN
                WR_ADDR2: begin
                    if (byte_done) begin
                        state <= WR_CHAR2;
                        idx   <= '0;
                        start_byte(hex_char(prev, 3'd0), 1'b1);
                    end
                end
                WR_CHAR2: begin
                    if (byte_done) begin
                        if (idx == 3'd7) begin
                            state <= WR_ADDR;
                            start_byte(8'h80, 1'b0);
                        end else begin
                            idx <= idx + 3'd1;
                            start_byte(hex_char(prev, idx + 3'd1), 1'b1);
                        end
                    end
                end
`endif
                WR_ADDR: begin
                    if (byte_done) begin
                        state <= WR_CHAR;
                        idx   <= '0;
                        start_byte(hex_char(disp, 3'd0), 1'b1);
                    end
                end
                WR_CHAR: begin
                    if (byte_done) begin
                        if (idx == 3'd7) begin
                            state <= IDLE;
                        end else begin
                            idx <= idx + 3'd1;
                            start_byte(hex_char(disp, idx + 3'd1), 1'b1);
                        end
                    end
                end
                default: state <= PWRUP;
            endcase

            // A strobe wins over the pending-clear above, so a same-cycle value stays pending.
            if (bus.out) begin
                pend_val <= bus.dados;
                pend     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lcd_saida_dados.sv
// Bench for lcd_saida_dados: scoreboard of expected {RS,DATA} bytes checked at every LCD_EN rise.
// Line-2 echo expectations are added when LCD_ECHO_LINE2_EN is defined.
module tb_lcd_saida_dados;
    localparam int POWERUP = 10;
    localparam int EN      = 2;
    localparam int WAIT    = 3;
    localparam int CLEAR   = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;

    lcd_saida_dados_if bus ();

    lcd_saida_dados #(
        .POWERUP_CYCLES(POWERUP),
        .EN_CYCLES     (EN),
        .WAIT_CYCLES   (WAIT),
        .CLEAR_CYCLES  (CLEAR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] val;
        logic [63:0] str;
    } vec_t;

    vec_t        vecs[6];
    logic [8:0]  sb[$];
    int          checks = 0;
    int          passed = 0;
`ifdef LCD_ECHO_LINE2_EN
    logic [63:0] shown_str = "00000000";
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic push_line(input logic [7:0] addr, input logic [63:0] s);
        sb.push_back({1'b0, addr});
        for (int i = 0; i < 8; i++) sb.push_back({1'b1, s[63-8*i -: 8]});
    endtask

    task automatic push_write(input logic [63:0] s);
`ifdef LCD_ECHO_LINE2_EN
        push_line(8'hC0, shown_str);
        shown_str = s;
`endif
        push_line(8'h80, s);
    endtask

    task automatic strobe(input logic [31:0] v);
        bus.out   = 1'b1;
        bus.dados = v;
        @(negedge clock);
        bus.out   = 1'b0;
    endtask

    task automatic wait_en(input logic lvl);
        int k = 0;
        while (bus.LCD_EN !== lvl && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (bus.LCD_EN !== lvl) begin
            checks++;
            $display("FAIL wait_en: LCD_EN stuck at %b, required %b", bus.LCD_EN, lvl);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy !== 1'b0 && k < 2000) begin
            @(negedge clock);
            k++;
        end
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    // Called just after reset release: power-up length, per-command waits, busy fall.
    task automatic run_init();
        int         n;
        logic [7:0] c;
        sb.push_back(9'h038);
        sb.push_back(9'h00C);
        sb.push_back(9'h001);
        sb.push_back(9'h006);
        n = 0;
        @(negedge clock);
        while (bus.LCD_EN !== 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("pwrup_len", 32'(n), 32'(POWERUP + 1));
        for (int i = 0; i < 4; i++) begin
            wait_en(1'b1);
            wait_en(1'b0);
            c = bus.LCD_DATA;
            n = 0;
            if (i < 3) begin
                while (bus.LCD_DATA === c && bus.LCD_EN === 1'b0 && n < 100) begin
                    n++;
                    @(negedge clock);
                end
                check("init_wait", 32'(n), (i == 2) ? 32'(CLEAR) : 32'(WAIT));
            end else begin
                while (bus.busy === 1'b1 && n < 100) begin
                    n++;
                    @(negedge clock);
                end
                check("busy_fall", 32'(n), 32'(WAIT));
            end
        end
    endtask

    // Monitor: pop/compare at each EN rise, check EN width and bus stability while EN is high.
    logic       en_d = 1'b0;
    int         hi_cnt = 0;
    logic [8:0] cap_b = '0;
    logic [8:0] mon_exp;
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.LCD_EN && !en_d) begin
                cap_b  = {bus.LCD_RS, bus.LCD_DATA};
                hi_cnt = 1;
                check("lcd_rw", 32'(bus.LCD_RW), 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL extra_byte: got rs=%0b data=0x%h, required no byte", bus.LCD_RS, bus.LCD_DATA);
                end else begin
                    mon_exp = sb.pop_front();
                    check("lcd_byte", 32'(cap_b), 32'(mon_exp));
                end
            end else if (bus.LCD_EN) begin
                hi_cnt++;
                check("pulse_stable", 32'({bus.LCD_RS, bus.LCD_DATA}), 32'(cap_b));
            end else if (en_d) begin
                check("en_width", 32'(hi_cnt), 32'(EN));
            end
        end
        en_d = bus.LCD_EN;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0].val = 32'h1234ABCD; vecs[0].str = "1234ABCD";
        vecs[1].val = 32'h00000001; vecs[1].str = "00000001";
        vecs[2].val = 32'h00000002; vecs[2].str = "00000002";
        vecs[3].val = 32'h9F0A5E6B; vecs[3].str = "9F0A5E6B";
        vecs[4].val = 32'hFEDCBA98; vecs[4].str = "FEDCBA98";
        vecs[5].val = 32'h00000000; vecs[5].str = "00000000";

        bus.out   = 1'b0;
        bus.dados = '0;
        reset     = 1'b1;
        repeat (2) @(negedge clock);
        strobe(32'hDEADBEEF);               // must be discarded by reset
        check("rst_en",   32'(bus.LCD_EN),   32'd0);
        check("rst_rs",   32'(bus.LCD_RS),   32'd0);
        check("rst_rw",   32'(bus.LCD_RW),   32'd0);
        check("rst_data", 32'(bus.LCD_DATA), 32'd0);
        check("rst_busy", 32'(bus.busy),     32'd1);
        @(posedge clock);
        #1 reset = 1'b0;
        run_init();

        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            push_write(vecs[i].str);
            strobe(vecs[i].val);
            check("busy_rise", 32'(bus.busy), 32'd1);
            wait_idle();
        end

        // Strobes during a write: latest wins, 5 never shown.
        @(negedge clock);
        push_write("CAFE0123");
        strobe(32'hCAFE0123);
        wait_en(1'b1);
        strobe(32'h00000005);
        repeat (5) @(negedge clock);
        push_write("FFFFFFFF");
        strobe(32'hFFFFFFFF);
        wait_idle();

        // Strobe on the exact cycle IDLE leaves for the address write.
        @(negedge clock);
        push_write("00000A01");
        push_write("00000B02");
        bus.out   = 1'b1;
        bus.dados = 32'h00000A01;
        @(negedge clock);
        bus.dados = 32'h00000B02;
        @(negedge clock);
        bus.out   = 1'b0;
        wait_idle();

        // Reset while EN is high, then full re-init.
        @(negedge clock);
        push_write("13572468");
        strobe(32'h13572468);
        wait_en(1'b1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_en",   32'(bus.LCD_EN), 32'd0);
        check("rst_mid_busy", 32'(bus.busy),   32'd1);
        sb.delete();
`ifdef LCD_ECHO_LINE2_EN
        shown_str = "00000000";
`endif
        @(posedge clock);
        #1 reset = 1'b0;
        run_init();

        @(negedge clock);
        push_write("0000FACE");
        strobe(32'h0000FACE);
        wait_idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/lcd_saida_dados.md
LCD_SAIDA_DADOS -- requirements
Module: lcd_saida_dados

Interface
REQ-001 The block SHALL have the parameter POWERUP_CYCLES, default 750000, meaning idle cycles after reset before the first LCD command (15 ms at 50 MHz).
REQ-002 The block SHALL have the parameter EN_CYCLES, default 12, meaning the LCD_EN high width in clock cycles.
REQ-003 The block SHALL have the parameter WAIT_CYCLES, default 2000, meaning the wait after each byte other than clear (40 us).
REQ-004 The block SHALL have the parameter CLEAR_CYCLES, default 82000, meaning the wait after clear command 0x01 (1.64 ms).
REQ-005 The block SHALL have these ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- out  in  1  one-cycle strobe from the control unit: an output instruction is executing.
- dados  in  32  value to display; sampled when out=1.
- busy  out  1  high while initialising or writing to the LCD.
- LCD_DATA  out  8  LCD data bus (write-only).
- LCD_RS  out  1  0=command, 1=character.
- LCD_RW  out  1  constant 0.
- LCD_EN  out  1  LCD enable strobe.

Function
REQ-006 Top FSM states SHALL be PWRUP, INIT, IDLE, WR_ADDR, WR_CHAR, plus WR_ADDR2 and WR_CHAR2 under REQ-020.
REQ-007 PWRUP SHALL count POWERUP_CYCLES cycles and then enter INIT.
REQ-008 INIT SHALL send the commands 0x38, 0x0C, 0x01, 0x06 in that order and then enter IDLE.
REQ-009 Each byte SHALL go through the byte engine: SETUP (1 cycle, RS/DATA driven, EN=0) -> PULSE (EN_CYCLES cycles, EN=1) -> WAIT (WAIT_CYCLES cycles, or CLEAR_CYCLES if the byte was command 0x01, EN=0) -> done.
REQ-010 LCD_RS and LCD_DATA SHALL stay stable from SETUP until the end of WAIT.
REQ-011 In IDLE with a value pending, the block SHALL send command 0x80 (WR_ADDR) followed by 8 characters (WR_CHAR), and then return to IDLE.
REQ-012 The characters SHALL be the hex digits of the captured word, most significant nibble first.
REQ-013 Nibbles 0-9 SHALL map to 0x30-0x39 and nibbles A-F to 0x41-0x46.
REQ-014 busy SHALL be 0 only in IDLE with no value pending.
REQ-015 When out=1, dados SHALL be loaded into a one-deep pending register and the pending flag SHALL be set.
REQ-016 A strobe that arrives while the pending flag is already set SHALL overwrite the pending value (latest wins).
REQ-017 The pending register SHALL be copied into the display register and the flag cleared on the cycle that IDLE leaves for WR_ADDR.
REQ-018 When a strobe and a pending-clear occur in the same cycle, the new value SHALL become pending and the flag SHALL remain set.
REQ-019 The display register SHALL NOT change while its 8 characters are being sent.

Configuration
REQ-020 Macro LCD_ECHO_LINE2_EN:
- Defined: before each line-1 write, the previously displayed word SHALL be written to line 2 (0xC0 followed by 8 hex characters; WR_ADDR2/WR_CHAR2).
- Defined, first write after reset: line 2 SHALL show "00000000".
- Undefined: line 2 SHALL never be written and the WR_ADDR2/WR_CHAR2 states SHALL not exist.

Reset
REQ-021 While reset=1 on a clock edge, the block SHALL go to PWRUP with the counters cleared, pending flag=0, display register=0, previous-word register=0, LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00 and busy=1.
REQ-022 Reset asserted in the middle of a byte (including while EN=1) SHALL drop LCD_EN on the next edge and restart the full init sequence.
REQ-023 A strobe in the same cycle as reset SHALL be discarded.

Verification (POWERUP_CYCLES=10, EN_CYCLES=2, WAIT_CYCLES=3, CLEAR_CYCLES=6)
REQ-024 Release reset -> EN pulses carry DATA 0x38, 0x0C, 0x01, 0x06 with RS=0; the wait after 0x01 is 6 cycles; busy falls after the last wait.
REQ-025 out=1, dados=0x1234ABCD in IDLE -> 0x80 sent with RS=0, then 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 sent with RS=1; busy=1 throughout, then busy=0.
REQ-026 During that write, strobe 0x00000005 and then 0xFFFFFFFF -> current line unchanged; next write shows "FFFFFFFF"; the value 5 is never displayed.
REQ-027 Strobe on the same cycle IDLE leaves for WR_ADDR -> the new value is displayed by a second write immediately after the first.
REQ-028 Reset asserted while EN=1 -> next edge EN=0 and busy=1; PWRUP count then restarts.
REQ-029 LCD_ECHO_LINE2_EN defined, strobe 0x1 then 0x2 -> second transaction writes 0xC0 + "00000001", then 0x80 + "00000002".
